// File: rtl/merge_2way.sv
// Streaming 2-way merge stage: pops the heads of two sorted-run FIFOs and emits one
// merged sorted run per input run pair through a registered valid/ready output.
module merge_2way #(
    parameter int unsigned width_p     = 8,
    parameter bit          ascending_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] a_data_i,
    input  logic               a_last_i,
    input  logic               a_valid_i,
    output logic               a_ready_o,
    input  logic [width_p-1:0] b_data_i,
    input  logic               b_last_i,
    input  logic               b_valid_i,
    output logic               b_ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    output logic               last_o,
    input  logic               ready_i
);

    typedef enum logic [1:0] {
        MERGE,
        DRAIN_A,
        DRAIN_B
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               ld;
    logic               a_wins;
    logic               pop_a;
    logic               pop_b;
    logic [width_p-1:0] data_next;
    logic               last_next;

    assign ld     = ~valid_o | ready_i;
    // Ties go to A so equal keys keep their A-before-B order.
    assign a_wins = ascending_p ? (a_data_i <= b_data_i) : (a_data_i >= b_data_i);

    assign a_ready_o = pop_a;
    assign b_ready_o = pop_b;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= MERGE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop_a      = 1'b0;
        pop_b      = 1'b0;
        data_next  = a_data_i;
        last_next  = 1'b0;
        if (!reset_i && ld) begin
            case (state)
                MERGE: begin
                    if (a_valid_i && b_valid_i) begin
                        if (a_wins) begin
                            pop_a     = 1'b1;
                            data_next = a_data_i;
                            if (a_last_i) begin
                                state_next = DRAIN_B;
                            end
                        end else begin
                            pop_b     = 1'b1;
                            data_next = b_data_i;
                            if (b_last_i) begin
                                state_next = DRAIN_A;
                            end
                        end
                    end
                end
                // One run is exhausted: the other side carries the merged run's last flag.
                DRAIN_A: begin
                    if (a_valid_i) begin
                        pop_a     = 1'b1;
                        data_next = a_data_i;
                        last_next = a_last_i;
                        if (a_last_i) begin
                            state_next = MERGE;
                        end
                    end
                end
                DRAIN_B: begin
                    if (b_valid_i) begin
                        pop_b     = 1'b1;
                        data_next = b_data_i;
                        last_next = b_last_i;
                        if (b_last_i) begin
                            state_next = MERGE;
                        end
                    end
                end
                default: begin
                    state_next = MERGE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
        end else if (ld) begin
            valid_o <= pop_a | pop_b;
            if (pop_a | pop_b) begin
                data_o <= data_next;
                last_o <= last_next;
            end
        end
    end

endmodule

// File: tb/tb_merge_2way.sv
// Bench for merge_2way: FIFO-like head models feed both an ascending and a descending
// instance; expected pops and outputs come from a stable sort of each run pair.
module tb_merge_2way;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] a_data_i;
    logic       a_last_i;
    logic       a_valid_i;
    logic [7:0] b_data_i;
    logic       b_last_i;
    logic       b_valid_i;
    logic       ready_i;

    logic       a_ready_asc, b_ready_asc, valid_asc, last_asc;
    logic [7:0] data_asc;
    logic       a_ready_desc, b_ready_desc, valid_desc, last_desc;
    logic [7:0] data_desc;

    merge_2way #(.width_p(8), .ascending_p(1'b1)) dut_asc (
        .clk_i(clk), .reset_i(reset_i),
        .a_data_i(a_data_i), .a_last_i(a_last_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_asc),
        .b_data_i(b_data_i), .b_last_i(b_last_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_asc),
        .valid_o(valid_asc), .data_o(data_asc), .last_o(last_asc), .ready_i(ready_i)
    );

    merge_2way #(.width_p(8), .ascending_p(1'b0)) dut_desc (
        .clk_i(clk), .reset_i(reset_i),
        .a_data_i(a_data_i), .a_last_i(a_last_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_desc),
        .b_data_i(b_data_i), .b_last_i(b_last_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_desc),
        .valid_o(valid_desc), .data_o(data_desc), .last_o(last_desc), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    bit desc      = 1'b0;
    bit aEn       = 1'b1;
    bit bEn       = 1'b1;
    bit gapMode   = 1'b0;
    bit rdyToggle = 1'b0;
    int readyMode = 0;

    // Heads of FIFO A/B as {last, key}; expected pops as {side, key}; outputs as {last, key}.
    bit [8:0] qa[$];
    bit [8:0] qb[$];
    bit [8:0] expPop[$];
    bit [8:0] expOut[$];
    int       runA[$];
    int       runB[$];

    bit       prevPop   = 1'b0;
    bit       prevLd    = 1'b0;
    bit       prevStall = 1'b0;
    bit [7:0] prevPopData;
    bit [8:0] prevOut;

    logic       obsA, obsB, obsValid, obsLast;
    logic [7:0] obsData;

    always_comb begin
        obsA     = desc ? a_ready_desc : a_ready_asc;
        obsB     = desc ? b_ready_desc : b_ready_asc;
        obsValid = desc ? valid_desc   : valid_asc;
        obsLast  = desc ? last_desc    : last_asc;
        obsData  = desc ? data_desc    : data_asc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit goesFirst(input bit [8:0] x, input bit [8:0] y);
        if (desc) return x[7:0] > y[7:0];
        return x[7:0] < y[7:0];
    endfunction

    // Queue one A run and one B run; expected order is a stable sort of A-then-B.
    task automatic applyStimulus();
        bit [8:0] m[$];
        bit [8:0] t;
        bit       isLast;
        foreach (runA[i]) begin
            isLast = (i == runA.size() - 1);
            qa.push_back({isLast, 8'(runA[i])});
            m.push_back({1'b0, 8'(runA[i])});
        end
        foreach (runB[i]) begin
            isLast = (i == runB.size() - 1);
            qb.push_back({isLast, 8'(runB[i])});
            m.push_back({1'b1, 8'(runB[i])});
        end
        for (int i = 1; i < m.size(); i++) begin
            for (int j = i; j > 0 && goesFirst(m[j], m[j-1]); j--) begin
                t      = m[j];
                m[j]   = m[j-1];
                m[j-1] = t;
            end
        end
        foreach (m[i]) begin
            isLast = (i == m.size() - 1);
            expPop.push_back(m[i]);
            expOut.push_back({isLast, m[i][7:0]});
        end
    endtask

    task automatic popSide(input bit side);
        bit [8:0] elem;
        checkOutput(side ? "pop_b_valid" : "pop_a_valid", side ? b_valid_i : a_valid_i, 1);
        if ((side ? b_valid_i : a_valid_i) !== 1'b1) return;
        elem = side ? qb.pop_front() : qa.pop_front();
        if (expPop.size() == 0) begin
            checkOutput("pop_extra", 32'(expPop.size()), 1);
            return;
        end
        checkOutput(side ? "pop_b" : "pop_a", {side, elem[7:0]}, expPop.pop_front());
        prevPop     = 1'b1;
        prevPopData = elem[7:0];
    endtask

    task automatic stepCycle();
        bit fire;
        @(negedge clk);
        if (gapMode) begin
            aEn = ($urandom_range(0, 3) != 0);
            bEn = ($urandom_range(0, 3) != 0);
        end
        a_valid_i = aEn && (qa.size() > 0);
        a_data_i  = a_valid_i ? qa[0][7:0] : 8'($urandom);
        a_last_i  = a_valid_i ? qa[0][8]   : 1'($urandom);
        b_valid_i = bEn && (qb.size() > 0);
        b_data_i  = b_valid_i ? qb[0][7:0] : 8'($urandom);
        b_last_i  = b_valid_i ? qb[0][8]   : 1'($urandom);
        case (readyMode)
            0: ready_i = 1'b1;
            1: begin rdyToggle = ~rdyToggle; ready_i = rdyToggle; end
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
        #2;
        if (prevPop) checkOutput("latency", {obsValid, obsData}, {1'b1, prevPopData});
        else if (prevLd) checkOutput("bubble", obsValid, 0);
        if (prevStall) checkOutput("stall_hold", {obsValid, obsLast, obsData}, {1'b1, prevOut});
        if (obsA || obsB) checkOutput("one_ready", obsA & obsB, 0);
        fire = obsValid & ready_i;
        if (fire) begin
            if (expOut.size() == 0) checkOutput("extra_out", fire, 0);
            else checkOutput("out", {obsLast, obsData}, expOut.pop_front());
        end
        prevPop = 1'b0;
        if (obsA === 1'b1) popSide(1'b0);
        if (obsB === 1'b1) popSide(1'b1);
        prevLd    = ~obsValid | ready_i;
        prevStall = obsValid & ~ready_i;
        prevOut   = {obsLast, obsData};
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((expOut.size() != 0 || qa.size() != 0 || qb.size() != 0) && n < maxCycles) begin
            stepCycle();
            n++;
        end
        checkOutput("drain_out", 32'(expOut.size()), 0);
        checkOutput("drain_fifos", 32'(qa.size() + qb.size()), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_i   = 1'b1;
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        a_data_i  = 8'd3;
        b_data_i  = 8'd4;
        @(negedge clk);
        #2;
        checkOutput("rst_valid", obsValid, 0);
        checkOutput("rst_data", {obsLast, obsData}, 0);
        checkOutput("rst_ready", {obsA, obsB}, 0);
        reset_i   = 1'b0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        qa.delete();
        qb.delete();
        expPop.delete();
        expOut.delete();
        prevPop   = 1'b0;
        prevLd    = 1'b1;
        prevStall = 1'b0;
    endtask

    task automatic randomPair();
        int k;
        runA.delete();
        runB.delete();
        k = $urandom_range(0, 40);
        repeat ($urandom_range(1, 5)) begin
            k += $urandom_range(0, 20);
            if (desc) runA.push_front(k); else runA.push_back(k);
        end
        k = $urandom_range(0, 40);
        repeat ($urandom_range(1, 5)) begin
            k += $urandom_range(0, 20);
            if (desc) runB.push_front(k); else runB.push_back(k);
        end
        applyStimulus();
    endtask

    initial begin
        reset_i   = 1'b1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        a_data_i  = '0;
        b_data_i  = '0;
        a_last_i  = 1'b0;
        b_last_i  = 1'b0;
        ready_i   = 1'b1;
        doReset();

        runA = '{1, 4, 7};  runB = '{2, 3, 9};  applyStimulus(); drain(50);
        runA = '{5};        runB = '{5};        applyStimulus(); drain(50);
        readyMode = 1;
        runA = '{1, 4, 7};  runB = '{2, 3, 9};  applyStimulus(); drain(50);
        readyMode = 0;
        runA = '{1};        runB = '{2, 3, 4};  applyStimulus(); drain(50);

        runA = '{3, 8};     runB = '{5};        applyStimulus();
        bEn = 1'b0;
        repeat (5) begin
            stepCycle();
            checkOutput("wait_pop", {obsA, obsB}, 0);
            checkOutput("wait_out", obsValid, 0);
        end
        bEn = 1'b1;
        drain(50);

        readyMode = 2;
        gapMode   = 1'b1;
        repeat (30) randomPair();
        drain(3000);
        gapMode   = 1'b0;
        aEn       = 1'b1;
        bEn       = 1'b1;
        readyMode = 0;

        desc = 1'b1;
        doReset();
        runA = '{9, 2};     runB = '{7, 1};     applyStimulus(); drain(50);
        applyStimulus();
        repeat (2) stepCycle();
        doReset();
        runA = '{9, 2};     runB = '{7, 1};     applyStimulus(); drain(50);

        readyMode = 2;
        gapMode   = 1'b1;
        repeat (20) randomPair();
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
